// File: rtl/weave_pkg.sv
// -----------------------------------------------------------------------------
// weave_pkg
// Shared types and constants for the weave pick sequencer.
//   weave_e   : weave type selected by cfg_weave (plain / twill / satin / custom)
//   state_e   : sequencer FSM states (idle / pick / done)
//   BASE_*    : 8-bit base lift masks for the built-in weave types
//   weave_base: helper returning the 8-bit base mask for a weave type
// -----------------------------------------------------------------------------
package weave_pkg;

  typedef enum logic [1:0] {
    WEAVE_PLAIN  = 2'd0,
    WEAVE_TWILL  = 2'd1,
    WEAVE_SATIN  = 2'd2,
    WEAVE_CUSTOM = 2'd3
  } weave_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PICK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] BASE_PLAIN = 8'h55;
  localparam logic [7:0] BASE_TWILL = 8'h33;
  localparam logic [7:0] BASE_SATIN = 8'h01;

  // Base mask for a weave type; custom passes the user mask through.
  function automatic logic [7:0] weave_base(input weave_e weave, input logic [7:0] custom);
    logic [7:0] base;
    case (weave)
      WEAVE_PLAIN:  base = BASE_PLAIN;
      WEAVE_TWILL:  base = BASE_TWILL;
      WEAVE_SATIN:  base = BASE_SATIN;
      WEAVE_CUSTOM: base = custom;
      default:      base = 8'h00;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/weave_rotl.sv
// -----------------------------------------------------------------------------
// weave_rotl
// Combinational WARPS-bit barrel rotate-left.
//   data_in  in  WARPS   value to rotate
//   offset   in  OFF_W   rotate amount, expected in 0..WARPS-1
//   data_out out WARPS   data_in rotated left by offset
// -----------------------------------------------------------------------------
module weave_rotl
  import weave_pkg::*;
#(
  parameter int WARPS = 8,
  parameter int OFF_W = $clog2(WARPS)
) (
  input  logic [WARPS-1:0] data_in,
  input  logic [OFF_W-1:0] offset,
  output logic [WARPS-1:0] data_out
);

  logic [2*WARPS-1:0] dbl_s;

  // Shift a doubled copy left; the upper half is the rotated word.
  always_comb begin
    dbl_s    = {data_in, data_in} << offset;
    data_out = dbl_s[2*WARPS-1:WARPS];
  end

endmodule

// File: rtl/weave_pick_sequencer.sv
// -----------------------------------------------------------------------------
// weave_pick_sequencer
// Sequences the picks of a woven pattern, emitting one warp-lift mask per pick.
// Configuration is latched on start; each pick mask is the base mask rotated
// left by a running offset that advances by cfg_shift (mod WARPS) per transfer.
//   clk, rst    single clock, synchronous active-high reset
//   start/abort begin a repeat (IDLE only) / cancel the current repeat
//   cfg_*       weave type, custom base, per-pick shift, picks per repeat
//   lift_mask   registered mask of the current pick, qualified by lift_valid
//   lift_ready  downstream accept; transfer = lift_valid & lift_ready
//   pick_idx    0-based index of the current pick
//   busy/done   busy in PICK and DONE; done pulses once per completed repeat
// -----------------------------------------------------------------------------
module weave_pick_sequencer
  import weave_pkg::*;
#(
  parameter int WARPS = 8,
  parameter int ROW_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cfg_weave,
  input  logic [WARPS-1:0] cfg_custom,
  input  logic [2:0]       cfg_shift,
  input  logic [ROW_W-1:0] cfg_rows,
  output logic [WARPS-1:0] lift_mask,
  output logic             lift_valid,
  input  logic             lift_ready,
  output logic [ROW_W-1:0] pick_idx,
  output logic             busy,
  output logic             done
);

  localparam int OFF_W = $clog2(WARPS);

  state_e             state_r;
  logic [WARPS-1:0]   base_r;
  logic [OFF_W-1:0]   shift_r;
  logic [ROW_W-1:0]   last_r;
  logic [OFF_W-1:0]   offset_r;

  logic [WARPS-1:0]   cfg_base_s;
  logic [OFF_W-1:0]   cfg_shift_mod_s;
  logic [OFF_W:0]     offset_sum_s;
  logic [OFF_W-1:0]   offset_nxt_s;
  logic [WARPS-1:0]   rot_base_s;
  logic [OFF_W-1:0]   rot_offset_s;
  logic [WARPS-1:0]   rot_mask_s;
  logic               xfer_s;

  assign xfer_s = lift_valid & lift_ready;

  // Base mask and shift (reduced mod WARPS) derived from the live config inputs.
  always_comb begin
    cfg_base_s      = WARPS'(weave_base(weave_e'(cfg_weave), 8'(cfg_custom)));
    cfg_shift_mod_s = OFF_W'(int'(cfg_shift) % WARPS);
    if (weave_e'(cfg_weave) == WEAVE_CUSTOM) begin
      cfg_base_s = cfg_custom;
    end else begin
      cfg_base_s = cfg_base_s;
    end
  end

  // Next rotation offset: running sum of the shift, wrapped modulo WARPS.
  always_comb begin
    offset_sum_s = {1'b0, offset_r} + {1'b0, shift_r};
    if (offset_sum_s >= (OFF_W+1)'(WARPS)) begin
      offset_nxt_s = OFF_W'(offset_sum_s - (OFF_W+1)'(WARPS));
    end else begin
      offset_nxt_s = offset_sum_s[OFF_W-1:0];
    end
  end

  // Rotator operands: fresh config at start of a repeat, latched config afterwards.
  always_comb begin
    rot_base_s   = base_r;
    rot_offset_s = offset_nxt_s;
    if (state_r == ST_IDLE) begin
      rot_base_s   = cfg_base_s;
      rot_offset_s = {OFF_W{1'b0}};
    end else begin
      rot_base_s   = base_r;
      rot_offset_s = offset_nxt_s;
    end
  end

  weave_rotl #(
    .WARPS (WARPS),
    .OFF_W (OFF_W)
  ) u_rotl (
    .data_in  (rot_base_s),
    .offset   (rot_offset_s),
    .data_out (rot_mask_s)
  );

  // Sequencer FSM with config latch, offset accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      base_r     <= {WARPS{1'b0}};
      shift_r    <= {OFF_W{1'b0}};
      last_r     <= {ROW_W{1'b0}};
      offset_r   <= {OFF_W{1'b0}};
      lift_mask  <= {WARPS{1'b0}};
      lift_valid <= 1'b0;
      pick_idx   <= {ROW_W{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          pick_idx <= {ROW_W{1'b0}};
          if (abort) begin
            state_r <= ST_IDLE;
          end else if (start) begin
            base_r     <= cfg_base_s;
            shift_r    <= cfg_shift_mod_s;
            // rows==0 wraps to all-ones, i.e. a full 2**ROW_W repeat.
            last_r     <= cfg_rows - {{(ROW_W-1){1'b0}}, 1'b1};
            offset_r   <= {OFF_W{1'b0}};
            lift_mask  <= rot_mask_s;
            lift_valid <= 1'b1;
            busy       <= 1'b1;
            state_r    <= ST_PICK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PICK: begin
          if (abort) begin
            lift_valid <= 1'b0;
            lift_mask  <= {WARPS{1'b0}};
            pick_idx   <= {ROW_W{1'b0}};
            busy       <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (xfer_s) begin
            if (pick_idx == last_r) begin
              lift_valid <= 1'b0;
              lift_mask  <= {WARPS{1'b0}};
              done       <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              offset_r  <= offset_nxt_s;
              lift_mask <= rot_mask_s;
              pick_idx  <= pick_idx + {{(ROW_W-1){1'b0}}, 1'b1};
              state_r   <= ST_PICK;
            end
          end else begin
            state_r <= ST_PICK;
          end
        end
        ST_DONE: begin
          pick_idx <= {ROW_W{1'b0}};
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          lift_valid <= 1'b0;
          lift_mask  <= {WARPS{1'b0}};
          pick_idx   <= {ROW_W{1'b0}};
          busy       <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weave_pick_sequencer.sv
// -----------------------------------------------------------------------------
// tb_weave_pick_sequencer
// Directed bench for weave_pick_sequencer with hand-computed expected masks.
// -----------------------------------------------------------------------------
module tb_weave_pick_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [1:0] cfg_weave;
  logic [7:0] cfg_custom;
  logic [2:0] cfg_shift;
  logic [3:0] cfg_rows;
  logic [7:0] lift_mask;
  logic       lift_valid;
  logic       lift_ready;
  logic [3:0] pick_idx;
  logic       busy;
  logic       done;

  int checks_cnt;
  int fail_cnt;

  weave_pick_sequencer #(.WARPS(8), .ROW_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_weave  (cfg_weave),
    .cfg_custom (cfg_custom),
    .cfg_shift  (cfg_shift),
    .cfg_rows   (cfg_rows),
    .lift_mask  (lift_mask),
    .lift_valid (lift_valid),
    .lift_ready (lift_ready),
    .pick_idx   (pick_idx),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, 32'(lift_valid), 32'd0);
    check_eq({tag, "_idx"},   32'(pick_idx),   32'd0);
    check_eq({tag, "_busy"},  32'(busy),       32'd0);
    check_eq({tag, "_done"},  32'(done),       32'd0);
  endtask

  logic [7:0] plain_exp [4];
  logic [7:0] twill_exp [4];
  logic [7:0] satin_exp [8];
  int         done_seen;

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    plain_exp  = '{8'h55, 8'hAA, 8'h55, 8'hAA};
    twill_exp  = '{8'h33, 8'h66, 8'hCC, 8'h99};
    satin_exp  = '{8'h01, 8'h08, 8'h40, 8'h02, 8'h10, 8'h80, 8'h04, 8'h20};

    rst = 1'b1; start = 1'b0; abort = 1'b0; lift_ready = 1'b1;
    cfg_weave = 2'd0; cfg_custom = 8'h00; cfg_shift = 3'd0; cfg_rows = 4'd0;
    tick(); tick();
    check_eq("rst_mask", 32'(lift_mask), 32'h0);
    check_idle("rst");
    rst = 1'b0;
    tick();

    // Plain, shift 1, 4 rows, always ready.
    cfg_weave = 2'd0; cfg_shift = 3'd1; cfg_rows = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("plain_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_eq("plain_mask",  32'(lift_mask),  32'(plain_exp[k]));
      check_eq("plain_idx",   32'(pick_idx),   32'(k));
      check_eq("plain_valid", 32'(lift_valid), 32'd1);
      tick();
    end
    check_eq("plain_done",    32'(done),       32'd1);
    check_eq("plain_dvalid",  32'(lift_valid), 32'd0);
    check_eq("plain_dbusy",   32'(busy),       32'd1);
    tick();
    check_idle("plain_end");

    // Twill, shift 1, rows 0 = 16 picks, exactly one done.
    cfg_weave = 2'd1; cfg_shift = 3'd1; cfg_rows = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 16; k++) begin
      check_eq("twill_mask", 32'(lift_mask), 32'(twill_exp[k % 4]));
      check_eq("twill_idx",  32'(pick_idx),  32'(k));
      if (done) done_seen++;
      tick();
    end
    check_eq("twill_done", 32'(done), 32'd1);
    tick();
    if (done) done_seen++;
    check_eq("twill_single_done", 32'(done_seen), 32'd0);
    check_idle("twill_end");

    // Satin, shift 3, 8 rows, one stall cycle before every transfer.
    cfg_weave = 2'd2; cfg_shift = 3'd3; cfg_rows = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_eq("satin_mask", 32'(lift_mask), 32'(satin_exp[k]));
      lift_ready = 1'b0;
      tick();
      check_eq("satin_hold_mask", 32'(lift_mask), 32'(satin_exp[k]));
      check_eq("satin_hold_idx",  32'(pick_idx),  32'(k));
      check_eq("satin_hold_vld",  32'(lift_valid), 32'd1);
      lift_ready = 1'b1;
      tick();
    end
    check_eq("satin_done", 32'(done), 32'd1);
    tick();

    // Custom F0, shift 2: abort after two transfers.
    cfg_weave = 2'd3; cfg_custom = 8'hF0; cfg_shift = 3'd2; cfg_rows = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("cust_mask0", 32'(lift_mask), 32'hF0);
    tick();
    check_eq("cust_mask1", 32'(lift_mask), 32'hC3);
    tick();
    check_eq("cust_mask2", 32'(lift_mask), 32'h0F);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort");
    tick();
    check_idle("abort_after");

    // Start and abort together in IDLE: stays idle.
    cfg_weave = 2'd0; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_idle("start_abort");

    // Shift 0: every pick repeats the base.
    cfg_weave = 2'd1; cfg_shift = 3'd0; cfg_rows = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("shift0_mask0", 32'(lift_mask), 32'h33);
    tick();
    check_eq("shift0_mask1", 32'(lift_mask), 32'h33);
    check_eq("shift0_idx1",  32'(pick_idx),  32'd1);
    tick();
    check_eq("shift0_done", 32'(done), 32'd1);
    tick();

    // Start during PICK with new config is ignored; then reset mid-repeat.
    cfg_weave = 2'd0; cfg_shift = 3'd1; cfg_rows = 4'd4; start = 1'b1;
    tick();
    lift_ready = 1'b0;
    cfg_weave = 2'd2; cfg_shift = 3'd3;
    tick();
    check_eq("restart_hold", 32'(lift_mask), 32'h55);
    check_eq("restart_idx",  32'(pick_idx),  32'd0);
    lift_ready = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart_mask1", 32'(lift_mask), 32'hAA);
    check_eq("restart_idx1",  32'(pick_idx),  32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_mask", 32'(lift_mask), 32'h0);
    check_idle("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
